// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue stage: decodes ALU operands/op into a one-entry
// valid/ready issue register and flags encodings the ALU cannot execute.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      alu_ctrl,
  output logic            is_branch,
  output logic            branch_ne,
  output logic            illegal,
  output logic [31:0]     issue_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;
  logic            unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign unused_rs1_field = ^instr[19:15];

  logic [XLEN-1:0] dec_a, dec_b;
  logic [3:0]      dec_ctrl;
  logic            dec_br, dec_ne, dec_legal;

  // Decode; any path that does not set dec_legal falls through to the illegal encoding.
  always_comb begin
    dec_a     = '0;
    dec_b     = '0;
    dec_ctrl  = ALU_ILL;
    dec_br    = 1'b0;
    dec_ne    = 1'b0;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec_a = rs1_data;
        dec_b = (opcode == OPC_OP) ? rs2_data : imm_i;
        case (funct3)
          3'b000: begin
            if (opcode == OPC_OP_IMM || funct7 == 7'b0000000) begin
              dec_ctrl = ALU_ADD; dec_legal = 1'b1;
            end else if (funct7 == 7'b0100000) begin
              dec_ctrl = ALU_SUB; dec_legal = 1'b1;
            end
          end
          3'b111: begin dec_ctrl = ALU_AND; dec_legal = (opcode == OPC_OP_IMM) || (funct7 == 7'b0); end
          3'b110: begin dec_ctrl = ALU_OR;  dec_legal = (opcode == OPC_OP_IMM) || (funct7 == 7'b0); end
          3'b100: begin dec_ctrl = ALU_XOR; dec_legal = (opcode == OPC_OP_IMM) || (funct7 == 7'b0); end
          3'b001, 3'b101: begin
            // The ALU shifts by the full operand, so the amount is masked to 5 bits here.
            dec_ctrl  = funct3[2] ? ALU_SRL : ALU_SLL;
            dec_b     = (opcode == OPC_OP) ? XLEN'(rs2_data[4:0]) : XLEN'(instr[24:20]);
            dec_legal = (funct7 == 7'b0000000);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LUI:   begin dec_b = imm_u; dec_ctrl = ALU_ADD; dec_legal = 1'b1; end
      OPC_AUIPC: begin dec_a = pc; dec_b = imm_u; dec_ctrl = ALU_ADD; dec_legal = 1'b1; end
      OPC_LOAD:  begin dec_a = rs1_data; dec_b = imm_i; dec_ctrl = ALU_ADD; dec_legal = 1'b1; end
      OPC_STORE: begin dec_a = rs1_data; dec_b = imm_s; dec_ctrl = ALU_ADD; dec_legal = 1'b1; end
      OPC_JAL, OPC_JALR: begin
        dec_a = pc; dec_b = XLEN'(4); dec_ctrl = ALU_ADD; dec_legal = 1'b1;
      end
      OPC_BRANCH: begin
        dec_a     = rs1_data;
        dec_b     = rs2_data;
        dec_ctrl  = ALU_SUB;
        dec_br    = 1'b1;
        dec_ne    = funct3[0];
        dec_legal = (funct3[2:1] == 2'b00);
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_a    = '0;
      dec_b    = '0;
      dec_ctrl = ALU_ILL;
      dec_br   = 1'b0;
      dec_ne   = 1'b0;
    end
  end

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic            is_branch_q, is_branch_d;
  logic            branch_ne_q, branch_ne_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     issue_count_q, issue_count_d;
  logic            load, fire;

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign fire     = out_valid_q && out_ready;

  // Issue register next state: flush beats load; data regs only move on load.
  always_comb begin
    out_valid_d   = out_valid_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_ctrl_d    = alu_ctrl_q;
    is_branch_d   = is_branch_q;
    branch_ne_d   = branch_ne_q;
    illegal_d     = illegal_q;
    issue_count_d = issue_count_q + 32'(fire);
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      a_d         = dec_a;
      b_d         = dec_b;
      alu_ctrl_d  = dec_ctrl;
      is_branch_d = dec_br;
      branch_ne_d = dec_ne;
      illegal_d   = !dec_legal;
    end else if (fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      alu_ctrl_q    <= ALU_ADD;
      is_branch_q   <= 1'b0;
      branch_ne_q   <= 1'b0;
      illegal_q     <= 1'b0;
      issue_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      a_q           <= a_d;
      b_q           <= b_d;
      alu_ctrl_q    <= alu_ctrl_d;
      is_branch_q   <= is_branch_d;
      branch_ne_q   <= branch_ne_d;
      illegal_q     <= illegal_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign a           = a_q;
  assign b           = b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign is_branch   = is_branch_q;
  assign branch_ne   = branch_ne_q;
  assign illegal     = illegal_q;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a transaction-level reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, is_branch, branch_ne, illegal;
  logic [31:0] instr, pc, rs1_data, rs2_data, a, b, issue_count;
  logic [3:0]  alu_ctrl;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .alu_ctrl(alu_ctrl),
    .is_branch(is_branch), .branch_ne(branch_ne), .illegal(illegal), .issue_count(issue_count)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        br;
    logic        ne;
    logic        ill;
  } op_t;

  int   total = 0;
  int   bad   = 0;
  logic        exp_valid;
  op_t         exp_op;
  logic [31:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference decode: what the ALU should be asked to compute for an instruction.
  function automatic op_t ref_op(input logic [31:0] ins, input logic [31:0] p, r1, r2);
    op_t r;
    int unsigned op, f3, f7;
    int          ctrl_of_f3 [8] = '{0, 5, -1, -1, 4, 6, 3, 2};
    logic [31:0] imm_i;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    imm_i = 32'($signed(ins[31:20]));
    r = '{a: 0, b: 0, ctrl: 4'hF, br: 1'b0, ne: 1'b0, ill: 1'b1};
    case (op)
      'h33: begin
        if (f7 == 0 && ctrl_of_f3[f3] >= 0)
          r = '{a: r1, b: (f3 == 1 || f3 == 5) ? r2 % 32 : r2, ctrl: 4'(ctrl_of_f3[f3]), br: 0, ne: 0, ill: 0};
        else if (f7 == 'h20 && f3 == 0)
          r = '{a: r1, b: r2, ctrl: 4'd1, br: 0, ne: 0, ill: 0};
      end
      'h13: begin
        if (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7)
          r = '{a: r1, b: imm_i, ctrl: 4'(ctrl_of_f3[f3]), br: 0, ne: 0, ill: 0};
        else if ((f3 == 1 || f3 == 5) && f7 == 0)
          r = '{a: r1, b: 32'(ins[24:20]), ctrl: 4'(ctrl_of_f3[f3]), br: 0, ne: 0, ill: 0};
      end
      'h37: r = '{a: 0, b: ins & 32'hFFFFF000, ctrl: 0, br: 0, ne: 0, ill: 0};
      'h17: r = '{a: p, b: ins & 32'hFFFFF000, ctrl: 0, br: 0, ne: 0, ill: 0};
      'h03: r = '{a: r1, b: imm_i, ctrl: 0, br: 0, ne: 0, ill: 0};
      'h23: r = '{a: r1, b: 32'($signed({ins[31:25], ins[11:7]})), ctrl: 0, br: 0, ne: 0, ill: 0};
      'h6F, 'h67: r = '{a: p, b: 4, ctrl: 0, br: 0, ne: 0, ill: 0};
      'h63: if (f3 < 2) r = '{a: r1, b: r2, ctrl: 4'd1, br: 1, ne: (f3 == 1), ill: 0};
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] r_type(input int f7, rs2, rs1, f3, rd, op);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [12] = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h37, 7'h17,
                              7'h03, 7'h23, 7'h6F, 7'h67, 7'h63, 7'h00};
    int sel;
    ins = $urandom;
    sel = int'($urandom_range(0, 11));
    ins[6:0] = (sel == 11) ? 7'($urandom) : ops[sel];
    if (ins[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
      ins[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    if (ins[6:0] == 7'h13 && ins[13:12] == 2'b01 && $urandom_range(0, 3) != 0)
      ins[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
    return ins;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, ".a"}, a, exp_op.a);
    chk({tag, ".b"}, b, exp_op.b);
    chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(exp_op.ctrl));
    chk({tag, ".is_branch"}, 32'(is_branch), 32'(exp_op.br));
    chk({tag, ".branch_ne"}, 32'(branch_ne), 32'(exp_op.ne));
    chk({tag, ".illegal"}, 32'(illegal), 32'(exp_op.ill));
    chk({tag, ".issue_count"}, issue_count, exp_cnt);
  endtask

  // One clock: drive inputs, check in_ready, advance the model, check registered outputs.
  task automatic step(input string tag, input logic rst, fl, iv, ordy,
                      input logic [31:0] ins, p, r1, r2);
    logic rdy;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
    #1;
    rdy = !exp_valid || ordy;
    if (!rst) chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    if (rst) begin
      exp_valid = 1'b0;
      exp_op    = '0;
      exp_cnt   = '0;
    end else begin
      if (exp_valid && ordy) exp_cnt = exp_cnt + 1;
      if (fl) exp_valid = 1'b0;
      else if (iv && rdy) begin
        exp_valid = 1'b1;
        exp_op    = ref_op(ins, p, r1, r2);
      end else if (ordy) exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  localparam logic [31:0] SUB_I  = 32'h402081B3;
  localparam logic [31:0] NOP_OP = 32'h00000013;

  logic [31:0] held_a, cnt_before;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    exp_valid = 1'b0; exp_op = '0; exp_cnt = '0;

    step("reset", 1, 0, 0, 0, '0, '0, '0, '0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    step("sub", 0, 0, 1, 1, SUB_I, 0, 10, 3);
    chk("sub.a", a, 32'd10); chk("sub.b", b, 32'd3); chk("sub.ctrl", 32'(alu_ctrl), 32'h1);
    step("sll", 0, 0, 1, 1, r_type(0, 2, 1, 1, 3, 'h33), 0, 7, 32'h23);
    chk("sll.b", b, 32'd3); chk("sll.ctrl", 32'(alu_ctrl), 32'h5);
    step("addi", 0, 0, 1, 1, 32'hFFF08193, 0, 5, 0);
    chk("addi.b", b, 32'hFFFFFFFF);
    step("auipc", 0, 0, 1, 1, 32'h12345197, 32'h100, 0, 0);
    chk("auipc.a", a, 32'h100); chk("auipc.b", b, 32'h12345000);
    step("sra", 0, 0, 1, 1, r_type('h20, 2, 1, 5, 3, 'h33), 0, 9, 9);
    chk("sra.illegal", 32'(illegal), 32'd1); chk("sra.ctrl", 32'(alu_ctrl), 32'hF);
    chk("sra.a", a, 32'd0);
    step("bne", 0, 0, 1, 1, r_type(0, 2, 1, 1, 0, 'h63), 0, 4, 5);
    chk("bne.br", 32'(is_branch), 32'd1); chk("bne.ne", 32'(branch_ne), 32'd1);
    chk("bne.ctrl", 32'(alu_ctrl), 32'h1);
    step("blt", 0, 0, 1, 1, r_type(0, 2, 1, 4, 0, 'h63), 0, 4, 5);
    chk("blt.illegal", 32'(illegal), 32'd1); chk("blt.br", 32'(is_branch), 32'd0);

    // Backpressure: entry must hold for three cycles, then be replaced without a bubble.
    step("bp_load", 0, 0, 1, 1, SUB_I, 0, 32'h55, 1);
    held_a = a;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold", 0, 0, 1, 0, NOP_OP, 0, 32'hAA, 0);
      chk("bp_hold.in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold.a", a, held_a);
    end
    cnt_before = issue_count;
    step("bp_release", 0, 0, 1, 1, NOP_OP, 0, 32'h77, 0);
    chk("bp_release.a", a, 32'h77);
    chk("bp_release.count", issue_count, cnt_before + 1);

    step("flush", 0, 1, 1, 1, SUB_I, 0, 1, 1);
    chk("flush.out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a held entry.
    step("rst_hold_load", 0, 0, 1, 0, SUB_I, 0, 3, 2);
    step("rst_hold", 0, 0, 1, 0, SUB_I, 0, 3, 2);
    step("rst_mid", 1, 0, 1, 0, SUB_I, 0, 3, 2);
    chk("rst_mid.count", issue_count, 32'd0);
    chk("rst_mid.ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);

    // Counter wrap: preload the counter, then complete one handshake.
    step("wrap_load", 0, 0, 1, 0, SUB_I, 0, 3, 2);
    force dut.issue_count_q = 32'hFFFFFFFF;
    #1 release dut.issue_count_q;
    exp_cnt = 32'hFFFFFFFF;
    step("wrap", 0, 0, 0, 1, NOP_OP, 0, 0, 0);
    chk("wrap.count", issue_count, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           rand_instr(), $urandom,
           $urandom, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
